stream_downsizer: RTL
=====================

Name: stream_downsizer

Overview:
- Width down-converter placed directly downstream of synch_fifo_2deep. It pops IN_WIDTH-bit words from the FIFO read port and emits them as RATIO = IN_WIDTH/OUT_WIDTH narrower beats, LSB-first.
- The output handshake uses the same wdata/wen/wrdy style as a FIFO write port, so the block can feed a narrower FIFO or a serial transmitter.
- Sustains one output beat per cycle with no bubble between consecutive words.

Parameters:
- IN_WIDTH, 32, width of words consumed from the upstream FIFO.
- OUT_WIDTH, 8, width of emitted beats. IN_WIDTH must be an integer multiple of OUT_WIDTH. A violation fails an elaboration-time check.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  IN_WIDTH  connects to FIFO rdata; valid whenever in_rrdy=1.
- in_rrdy  input  1  connects to FIFO rrdy (FIFO not empty).
- in_ren  output  1  connects to FIFO ren; a pop occurs on a cycle with in_ren && in_rrdy.
- out_data  output  OUT_WIDTH  current beat.
- out_wen  output  1  beat valid.
- out_wrdy  input  1  downstream can accept a beat; a transfer occurs on a cycle with out_wen && out_wrdy.
- out_last  output  1  high on the final beat of each word.

Behaviour:
- Derived constants:
  - RATIO = IN_WIDTH/OUT_WIDTH.
  - CW = max(1, $clog2(RATIO)).
- State:
  - full (1 bit)
  - shreg (IN_WIDTH)
  - cnt (CW bits)
- Reset: full=0, cnt=0, shreg=0. As a result out_wen=0, out_last=0, out_data=0, and in_ren=0 while rst is high.
- Combinational outputs:
  - out_wen = full
  - out_data = shreg[OUT_WIDTH-1:0]
  - out_last = full && (cnt == RATIO-1)
  - in_ren = in_rrdy && !rst && (!full || (out_wrdy && out_last))
- in_ren may depend combinationally on in_rrdy and out_wrdy. in_ren is never asserted while in_rrdy=0.
- Pop (in_ren=1): shreg <= in_data, cnt <= 0, full <= 1. The first beat of that word is visible on the next cycle (latency 1 cycle from pop).
- Non-last beat accepted: shreg <= shreg >> OUT_WIDTH, cnt <= cnt+1.
- Last beat accepted:
  - With a simultaneous pop: load the new word as above, giving back-to-back words with no bubble.
  - Without a pop: full <= 0.
- Stall (out_wen && !out_wrdy): out_data, out_last and shreg hold. No pop occurs.
- Empty upstream while idle: full stays 0 and out_wen stays 0 until in_rrdy rises.
- RATIO == 1:
  - cnt stays 0 and out_last=full.
  - The block acts as a one-deep registered pipeline stage at full throughput.
- Reset mid-word: the partially emitted word is discarded. The next word popped after reset starts at beat 0.
- No data is reordered, duplicated or dropped outside reset.

Decomposition:
- A shared package stream_pkg holds:
  - function ratio_of(in_w, out_w)
  - function cnt_width(ratio), the max(1, clog2) rule
  - so the matching upsizer (planned later) uses identical rules.
- No sub-module. The counter and shift register are inline.
- Top-level test harness instantiates synch_fifo_2deep (WIDTH=IN_WIDTH) feeding stream_downsizer.

Test Plan:
- Single word: reset, then push 0xDDCCBBAA into FIFO with out_wrdy=1 -> out_data 0xAA,0xBB,0xCC,0xDD on 4 consecutive cycles; out_last only on 0xDD; in_ren pulses exactly once.
- Back-to-back: push 0x03020100 and 0x07060504, out_wrdy=1 -> 8 beats 0x00..0x07 on 8 consecutive cycles, no gap, out_last on 0x03 and 0x07; second pop coincides with beat 0x03 transfer.
- Backpressure: same two words, out_wrdy toggling 1,0,0,1,... -> beat sequence unchanged; out_data stable during every stall cycle; no pop while last beat is stalled.
- Upstream starvation: push one word, then wait 5 cycles before pushing next -> out_wen drops after first word's last beat, rises 1 cycle after second pop, FIFO never underflows (in_ren=0 while in_rrdy=0).
- Reset mid-word: assert rst after beat 0xBB of 0xDDCCBBAA -> next cycle out_wen=0; subsequent word 0x44332211 emits 0x11,0x22,0x33,0x44.
- RATIO=1 (IN_WIDTH=OUT_WIDTH=8): stream 0x10..0x1F with random out_wrdy -> identical sequence out, out_last=1 on every beat, sustained 1 beat/cycle when out_wrdy=1.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared width-conversion rules for the stream down/up-sizers.
// Both converters size their beat counters from these helpers, so they always agree.
package stream_pkg;

  function automatic int ratio_of(input int in_w, input int out_w);
    return (out_w > 0) ? in_w / out_w : 1;
  endfunction

  // A counter always needs at least one bit, even when the ratio is 1.
  function automatic int cnt_width(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/stream_downsizer_if.sv
// Bundles the FIFO-read side and the FIFO-write-style output side of the downsizer.
// The master modport is the downsizer's view; the slave modport is the surrounding logic.
interface stream_downsizer_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
);
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_rrdy;
  logic                 in_ren;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_wen;
  logic                 out_wrdy;
  logic                 out_last;

  modport master (
    input  in_data, in_rrdy, out_wrdy,
    output in_ren, out_data, out_wen, out_last
  );

  modport slave (
    output in_data, in_rrdy, out_wrdy,
    input  in_ren, out_data, out_wen, out_last
  );
endinterface

// File: rtl/stream_downsizer.sv
// Splits each word popped from an upstream FIFO into RATIO narrower beats, LSB first,
// refilling on the last accepted beat so consecutive words stream with no bubble.
module stream_downsizer
  import stream_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  stream_downsizer_if.master bus
);

  localparam int RATIO = ratio_of(IN_WIDTH, OUT_WIDTH);
  localparam int CW    = cnt_width(RATIO);

  if (OUT_WIDTH < 1 || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_widths
    $error("stream_downsizer: IN_WIDTH must be an integer multiple of OUT_WIDTH");
  end

  logic                full;
  logic [IN_WIDTH-1:0] shreg;
  logic [CW-1:0]       cnt;
  logic                last;
  logic                pop;

  assign last = full && (cnt == CW'(RATIO - 1));
  // A pop is only allowed into an empty holder or alongside the final beat's transfer.
  assign pop  = bus.in_rrdy && !rst && (!full || (bus.out_wrdy && last));

  assign bus.in_ren   = pop;
  assign bus.out_wen  = full;
  assign bus.out_last = last;
  assign bus.out_data = shreg[OUT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= 1'b0;
      cnt   <= '0;
      shreg <= '0;
    end else if (pop) begin
      full  <= 1'b1;
      cnt   <= '0;
      shreg <= bus.in_data;
    end else if (full && bus.out_wrdy) begin
      if (last) begin
        full <= 1'b0;
      end else begin
        shreg <= shreg >> OUT_WIDTH;
        cnt   <= cnt + CW'(1);
      end
    end
  end

endmodule
